// File: rtl/led_bit_rx.sv
// Serial LED-strip bit receiver: measures high/low times of a single-wire line,
// decodes bits by pulse width, assembles LSB-first bytes and tracks frame boundaries.
`timescale 1ns/1ps
module led_bit_rx #(
   parameter logic [15:0] T_BIT_THRESH = 16'd120,
   parameter logic [15:0] T_HIGH_MAX   = 16'd400,
   parameter logic [15:0] T_RESET      = 16'd10000
) (
   input  logic        clk_in,
   input  logic        ar,
   input  logic        din,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        frame_active,
   output logic        frame_end,
   output logic        bit_err,
   output logic [15:0] byte_count
);

   typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

   state_t      state_q, state_d;

   logic        din_m_q, din_s_q, din_p_q;
   logic        din_rise, din_fall;

   logic [15:0] hi_cnt_q, hi_cnt_d;
   logic [15:0] lo_cnt_q, lo_cnt_d;

   logic        dec_vld_q, dec_vld_d;
   logic        dec_bit_q, dec_bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_idx_q, bit_idx_d;

   logic [7:0]  byte_out_q, byte_out_d;
   logic        byte_valid_q, byte_valid_d;
   logic        frame_active_q, frame_active_d;
   logic        frame_end_q, frame_end_d;
   logic        bit_err_q, bit_err_d;
   logic [15:0] byte_count_q, byte_count_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign din_rise = din_s_q & ~din_p_q;
   assign din_fall = ~din_s_q & din_p_q;

   always_ff @(posedge clk_in or posedge ar) begin
      if (ar) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      hi_cnt_d       = hi_cnt_q;
      lo_cnt_d       = lo_cnt_q;
      dec_vld_d      = 1'b0;
      dec_bit_d      = dec_bit_q;
      shreg_d        = shreg_q;
      bit_idx_d      = bit_idx_q;
      byte_out_d     = byte_out_q;
      byte_valid_d   = 1'b0;
      frame_active_d = frame_active_q;
      frame_end_d    = 1'b0;
      bit_err_d      = 1'b0;
      byte_count_d   = byte_count_q;

      if (din_rise) begin
         hi_cnt_d = 16'd1;
      end else if (din_s_q) begin
         hi_cnt_d = sat_inc16(hi_cnt_q);
      end

      if (din_rise) begin
         lo_cnt_d = 16'd0;
      end else if (!din_s_q && (lo_cnt_q < T_RESET)) begin
         lo_cnt_d = lo_cnt_q + 16'd1;
      end

      unique case (state_q)
         SYNC: begin
            if (din_rise && (lo_cnt_q == T_RESET)) begin
               state_d = HIGH;
            end
         end
         IDLE: begin
            if (din_rise) begin
               state_d = HIGH;
            end
         end
         HIGH: begin
            // An over-long pulse wins over a simultaneous falling edge.
            if (hi_cnt_q > T_HIGH_MAX) begin
               bit_err_d      = 1'b1;
               bit_idx_d      = 3'd0;
               frame_active_d = 1'b0;
               state_d        = SYNC;
            end else if (din_fall) begin
               dec_vld_d = 1'b1;
               dec_bit_d = (hi_cnt_q >= T_BIT_THRESH);
               state_d   = LOW;
            end
         end
         LOW: begin
            if (lo_cnt_q == T_RESET) begin
               frame_end_d    = 1'b1;
               frame_active_d = 1'b0;
               bit_err_d      = (bit_idx_q != 3'd0);
               bit_idx_d      = 3'd0;
               state_d        = din_rise ? HIGH : IDLE;
            end else if (din_rise) begin
               state_d = HIGH;
            end
         end
         default: state_d = SYNC;
      endcase

      // Decoded bit is assembled one cycle after the falling edge is seen.
      if (dec_vld_q) begin
         shreg_d = {dec_bit_q, shreg_q[7:1]};
         if (!frame_active_q) begin
            frame_active_d = 1'b1;
            byte_count_d   = 16'd0;
         end
         if (bit_idx_q == 3'd7) begin
            byte_out_d   = {dec_bit_q, shreg_q[7:1]};
            byte_valid_d = 1'b1;
            bit_idx_d    = 3'd0;
            byte_count_d = sat_inc16(frame_active_q ? byte_count_q : 16'd0);
         end else begin
            bit_idx_d = bit_idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge ar) begin
      if (ar) begin
         din_m_q        <= 1'b0;
         din_s_q        <= 1'b0;
         din_p_q        <= 1'b0;
         hi_cnt_q       <= 16'd0;
         lo_cnt_q       <= 16'd0;
         dec_vld_q      <= 1'b0;
         dec_bit_q      <= 1'b0;
         shreg_q        <= 8'd0;
         bit_idx_q      <= 3'd0;
         byte_out_q     <= 8'd0;
         byte_valid_q   <= 1'b0;
         frame_active_q <= 1'b0;
         frame_end_q    <= 1'b0;
         bit_err_q      <= 1'b0;
         byte_count_q   <= 16'd0;
      end else begin
         din_m_q        <= din;
         din_s_q        <= din_m_q;
         din_p_q        <= din_s_q;
         hi_cnt_q       <= hi_cnt_d;
         lo_cnt_q       <= lo_cnt_d;
         dec_vld_q      <= dec_vld_d;
         dec_bit_q      <= dec_bit_d;
         shreg_q        <= shreg_d;
         bit_idx_q      <= bit_idx_d;
         byte_out_q     <= byte_out_d;
         byte_valid_q   <= byte_valid_d;
         frame_active_q <= frame_active_d;
         frame_end_q    <= frame_end_d;
         bit_err_q      <= bit_err_d;
         byte_count_q   <= byte_count_d;
      end
   end

   assign byte_out     = byte_out_q;
   assign byte_valid   = byte_valid_q;
   assign frame_active = frame_active_q;
   assign frame_end    = frame_end_q;
   assign bit_err      = bit_err_q;
   assign byte_count   = byte_count_q;

endmodule
